// File: rtl/terminal_fifo_bank_if.sv
// rtl/terminal_fifo_bank_if.sv - push/pop/status bundle between the terminal agents and the FIFO bank
interface terminal_fifo_bank_if #(
    parameter int CHANNELS  = 8,
    parameter int PCKG_SZ   = 20,
    parameter int DEPTH     = 4,
    parameter int OVF_CNT_W = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CHANNELS-1:0]           push;
    logic [CHANNELS*PCKG_SZ-1:0]   data_in;
    logic [CHANNELS-1:0]           ovwr_mode;
    logic [CHANNELS-1:0]           flush;
    logic [CHANNELS-1:0]           popin;
    logic                          ovf_clr;
    logic [CHANNELS-1:0]           pndng_i_in;
    logic [CHANNELS*PCKG_SZ-1:0]   data_out_i_in;
    logic [CHANNELS-1:0]           full;
    logic [CHANNELS*CNT_W-1:0]     count;
    logic [CHANNELS*OVF_CNT_W-1:0] ovf_cnt;

    modport master (
        output push, data_in, ovwr_mode, flush, popin, ovf_clr,
        input  pndng_i_in, data_out_i_in, full, count, ovf_cnt
    );

    modport slave (
        input  push, data_in, ovwr_mode, flush, popin, ovf_clr,
        output pndng_i_in, data_out_i_in, full, count, ovf_cnt
    );
endinterface

// File: rtl/terminal_fifo_bank.sv
// rtl/terminal_fifo_bank.sv - per-terminal FWFT input FIFOs with drop/overwrite policy and overflow counters
module terminal_fifo_bank #(
    parameter int CHANNELS  = 8,
    parameter int PCKG_SZ   = 20,
    parameter int DEPTH     = 4,
    parameter int OVF_CNT_W = 8
) (
    input logic                   clk,
    input logic                   reset,
    terminal_fifo_bank_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PCKG_SZ-1:0]   mem [DEPTH];
        logic [PW-1:0]        rd_ptr, wr_ptr;
        logic [CNT_W-1:0]     cnt;
        logic [OVF_CNT_W-1:0] ovf;
        logic                 is_empty, is_full, wr_en, rd_en, ovf_inc;

        // A full push without a pop either loses the new word or evicts the head.
        always_comb begin
            is_empty = (cnt == '0);
            is_full  = (cnt == CNT_W'(DEPTH));
            wr_en    = !bus.flush[c] && bus.push[c] &&
                       (!is_full || bus.popin[c] || bus.ovwr_mode[c]);
            rd_en    = !bus.flush[c] && !is_empty &&
                       (bus.popin[c] || (bus.push[c] && is_full && bus.ovwr_mode[c]));
            ovf_inc  = !bus.flush[c] && bus.push[c] && is_full && !bus.popin[c];
        end

        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr] <= bus.data_in[c*PCKG_SZ +: PCKG_SZ];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                ovf    <= '0;
            end else begin
                if (bus.ovf_clr)                 ovf <= '0;
                else if (ovf_inc && ovf != '1)   ovf <= ovf + 1'b1;

                if (bus.flush[c]) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (wr_en) wr_ptr <= nxt(wr_ptr);
                    if (rd_en) rd_ptr <= nxt(rd_ptr);
                    case ({wr_en, rd_en})
                        2'b10:   cnt <= cnt + 1'b1;
                        2'b01:   cnt <= cnt - 1'b1;
                        default: cnt <= cnt;
                    endcase
                end
            end
        end

        assign bus.pndng_i_in[c]                         = !is_empty;
        assign bus.full[c]                               = is_full;
        assign bus.count[c*CNT_W +: CNT_W]               = cnt;
        assign bus.ovf_cnt[c*OVF_CNT_W +: OVF_CNT_W]     = ovf;
        assign bus.data_out_i_in[c*PCKG_SZ +: PCKG_SZ]   = is_empty ? '0 : mem[rd_ptr];
    end
endmodule

// File: tb/tb_terminal_fifo_bank.sv
// tb/tb_terminal_fifo_bank.sv - scoreboard bench for terminal_fifo_bank
module tb_terminal_fifo_bank;
    localparam int CH = 8;
    localparam int W  = 20;
    localparam int D  = 4;
    localparam int OW = 2;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    terminal_fifo_bank_if #(.CHANNELS(CH), .PCKG_SZ(W), .DEPTH(D), .OVF_CNT_W(OW)) bus ();

    terminal_fifo_bank #(.CHANNELS(CH), .PCKG_SZ(W), .DEPTH(D), .OVF_CNT_W(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  sbq [CH][$];
    int            exp_ovf [CH];
    logic [CH-1:0] p_push, p_pop, p_flush, p_ovwr;
    logic [W-1:0]  p_data [CH];
    logic          p_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("ch%0d_pndng", c), 32'(bus.pndng_i_in[c]), 32'(sbq[c].size() != 0));
            chk($sformatf("ch%0d_full", c),  32'(bus.full[c]),       32'(sbq[c].size() == D));
            chk($sformatf("ch%0d_count", c), 32'(bus.count[c*CW +: CW]), 32'(sbq[c].size()));
            chk($sformatf("ch%0d_ovf", c),   32'(bus.ovf_cnt[c*OW +: OW]), 32'(exp_ovf[c]));
            chk($sformatf("ch%0d_head", c),  32'(bus.data_out_i_in[c*W +: W]),
                32'((sbq[c].size() != 0) ? sbq[c][0] : '0));
        end
    endtask

    task automatic clear_strobes();
        p_push = '0; p_pop = '0; p_flush = '0; p_clr = 1'b0;
        bus.push = '0; bus.popin = '0; bus.flush = '0; bus.ovf_clr = 1'b0;
    endtask

    task automatic cycle();
        bit inc;
        bus.push = p_push; bus.popin = p_pop; bus.flush = p_flush;
        bus.ovwr_mode = p_ovwr; bus.ovf_clr = p_clr;
        for (int c = 0; c < CH; c++) bus.data_in[c*W +: W] = p_data[c];
        for (int c = 0; c < CH; c++) begin
            inc = 1'b0;
            if (p_flush[c]) begin
                sbq[c].delete();
            end else begin
                if (p_pop[c] && sbq[c].size() > 0) void'(sbq[c].pop_front());
                if (p_push[c]) begin
                    if (sbq[c].size() == D) begin
                        inc = 1'b1;
                        if (p_ovwr[c]) begin
                            void'(sbq[c].pop_front());
                            sbq[c].push_back(p_data[c]);
                        end
                    end else begin
                        sbq[c].push_back(p_data[c]);
                    end
                end
            end
            if (p_clr) exp_ovf[c] = 0;
            else if (inc && exp_ovf[c] < (1 << OW) - 1) exp_ovf[c]++;
        end
        @(posedge clk);
        #1;
        clear_strobes();
        check_all();
    endtask

    task automatic push1(input int c, input logic [W-1:0] d);
        p_push[c] = 1'b1; p_data[c] = d; cycle();
    endtask

    task automatic pop1(input int c);
        p_pop[c] = 1'b1; cycle();
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin p_data[c] = '0; exp_ovf[c] = 0; end
        p_ovwr = '0;
        clear_strobes();
        bus.data_in = '0;
        bus.ovwr_mode = '0;

        // T1: reset held with pushes on every channel
        reset = 1'b0;
        bus.push = '1;
        repeat (5) begin
            @(posedge clk); #1;
            check_all();
        end
        @(negedge clk);
        reset = 1'b1;
        bus.push = '0;
        #1 check_all();

        // T2: FWFT ordering on ch0
        push1(0, 20'h00001);
        push1(0, 20'h00002);
        push1(0, 20'h00003);
        chk("t2_count3", 32'(bus.count[0 +: CW]), 32'd3);
        chk("t2_head1", 32'(bus.data_out_i_in[0 +: W]), 32'h1);
        repeat (3) pop1(0);
        chk("t2_pndng0", 32'(bus.pndng_i_in[0]), 32'd0);

        // T3: drop-new on ch2
        p_ovwr[2] = 1'b0;
        for (int i = 0; i < 5; i++) push1(2, 20'hA0000 + 20'(i));
        chk("t3_full", 32'(bus.full[2]), 32'd1);
        chk("t3_ovf", 32'(bus.ovf_cnt[2*OW +: OW]), 32'd1);
        chk("t3_head", 32'(bus.data_out_i_in[2*W +: W]), 32'hA0000);
        repeat (4) pop1(2);

        // T4: overwrite-oldest on ch3
        p_ovwr[3] = 1'b1;
        for (int i = 0; i < 6; i++) push1(3, 20'hB0000 + 20'(i));
        chk("t4_ovf", 32'(bus.ovf_cnt[3*OW +: OW]), 32'd2);
        chk("t4_head", 32'(bus.data_out_i_in[3*W +: W]), 32'hB0002);
        p_ovwr[3] = 1'b0;
        repeat (4) pop1(3);

        // T5: boundaries on ch1
        for (int i = 0; i < 4; i++) push1(1, 20'hC0000 + 20'(i));
        p_push[1] = 1'b1; p_pop[1] = 1'b1; p_data[1] = 20'hC0010; cycle();
        chk("t5_full_pp_count", 32'(bus.count[1*CW +: CW]), 32'd4);
        chk("t5_full_pp_ovf", 32'(bus.ovf_cnt[1*OW +: OW]), 32'd0);
        repeat (4) pop1(1);
        pop1(1);
        chk("t5_pop_empty", 32'(bus.count[1*CW +: CW]), 32'd0);
        p_push[1] = 1'b1; p_pop[1] = 1'b1; p_data[1] = 20'hC0020; cycle();
        push1(1, 20'hC0021);
        p_flush[1] = 1'b1; p_push[1] = 1'b1; p_data[1] = 20'hC0022; cycle();
        chk("t5_flush_count", 32'(bus.count[1*CW +: CW]), 32'd0);
        chk("t5_flush_pndng", 32'(bus.pndng_i_in[1]), 32'd0);
        push1(1, 20'hC0030);
        pop1(1);

        // T6: saturation and clear on ch5 with concurrent ch4 traffic
        for (int i = 0; i < 4; i++) push1(5, 20'hD0000 + 20'(i));
        for (int i = 0; i < 5; i++) begin
            p_push[5] = 1'b1; p_data[5] = 20'hD0100 + 20'(i);
            p_push[4] = 1'b1; p_data[4] = 20'hE0000 + 20'(i);
            p_pop[4]  = (i > 1);
            cycle();
        end
        chk("t6_sat", 32'(bus.ovf_cnt[5*OW +: OW]), 32'd3);
        p_clr = 1'b1; p_push[5] = 1'b1; p_data[5] = 20'hD0200; cycle();
        chk("t6_clr", 32'(bus.ovf_cnt[5*OW +: OW]), 32'd0);
        repeat (3) pop1(4);
        repeat (4) pop1(5);

        // Mid-operation async reset
        push1(6, 20'hF0001);
        #2 reset = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) begin sbq[c].delete(); exp_ovf[c] = 0; end
        check_all();
        @(negedge clk);
        reset = 1'b1;
        push1(6, 20'hF0002);
        pop1(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
